// File: rtl/pipe_rca.sv
// rtl/pipe_rca.sv - pipelined ripple-carry adder/subtractor, SEG carry bits resolved per stage
module pipe_rca #(
    parameter int N   = 16,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         signed_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out,
    output logic         ovf
);
    localparam int STAGES = N / SEG;
    localparam int L      = STAGES - 1;

    logic advance;
    logic top;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SEG;
        localparam int REM = N - LO;

        // Operands shrink by SEG bits per stage; results grow by SEG bits per stage.
        logic [REM-1:0]    in_a, in_b;
        logic              in_v, in_c, in_sub, in_sgn, in_msx;
        logic [SEG-1:0]    sum;
        logic              c_out;
        logic [LO+SEG-1:0] nxt_res;
        logic [LO+SEG-1:0] res;
        logic              v, c, t_sub, t_sgn, msx;

        if (k == 0) begin : g_src
            assign in_a    = a;
            assign in_b    = b ^ {N{sub}};
            assign in_v    = in_valid;
            assign in_c    = sub;
            assign in_sub  = sub;
            assign in_sgn  = signed_mode;
            // XOR of the operand sign bits after B inversion; forms the sign-extension bit
            assign in_msx  = a[N-1] ^ b[N-1] ^ sub;
            assign nxt_res = sum;
        end else begin : g_src
            assign in_a    = g_stage[k-1].g_ops.rem_a;
            assign in_b    = g_stage[k-1].g_ops.rem_b;
            assign in_v    = g_stage[k-1].v;
            assign in_c    = g_stage[k-1].c;
            assign in_sub  = g_stage[k-1].t_sub;
            assign in_sgn  = g_stage[k-1].t_sgn;
            assign in_msx  = g_stage[k-1].msx;
            assign nxt_res = {sum, g_stage[k-1].res};
        end

        always_comb begin
            logic cy;
            cy  = in_c;
            sum = '0;
            for (int i = 0; i < SEG; i++) begin
                sum[i] = in_a[i] ^ in_b[i] ^ cy;
                cy     = (in_a[i] & in_b[i]) | (cy & (in_a[i] ^ in_b[i]));
            end
            c_out = cy;
        end

        if (k < STAGES - 1) begin : g_ops
            logic [REM-SEG-1:0] rem_a, rem_b;
            always_ff @(posedge clk) begin
                if (advance) begin
                    rem_a <= in_a[REM-1:SEG];
                    rem_b <= in_b[REM-1:SEG];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v <= 1'b0;
            end else if (advance) begin
                v <= in_v;
            end
            if (advance) begin
                c     <= c_out;
                res   <= nxt_res;
                t_sub <= in_sub;
                t_sgn <= in_sgn;
                msx   <= in_msx;
            end
        end
    end

    always_comb begin
        top = g_stage[L].t_sgn ? (g_stage[L].msx ^ g_stage[L].c)
                               : (g_stage[L].c ^ g_stage[L].t_sub);
        out_valid = g_stage[L].v;
        out       = '0;
        ovf       = 1'b0;
        if (g_stage[L].v) begin
            out = {top, g_stage[L].res};
            ovf = g_stage[L].t_sgn ? (top ^ g_stage[L].res[N-1]) : top;
        end
    end
endmodule

// File: tb/tb_pipe_rca.sv
// tb/tb_pipe_rca.sv - scoreboard bench for pipe_rca against an arithmetic reference model
module tb_pipe_rca;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         sub = 1'b0;
    logic         signed_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N:0]   out;
    logic         ovf;

    always #5 clk = ~clk;

    pipe_rca #(.N(N), .SEG(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf)
    );

    typedef struct {
        logic [N:0] res;
        logic       flag;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         lat_strict = 1'b0;
    bit         holding = 1'b0;
    logic [N:0] held_out;
    logic       held_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Exact arithmetic on extended operands, truncated to N+1 bits
    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                   input logic s, input logic sm, input int acc);
        longint ex, ey, r;
        exp_t   e;
        ex     = sm ? longint'($signed(x)) : longint'(x);
        ey     = sm ? longint'($signed(y)) : longint'(y);
        r      = s ? (ex - ey) : (ex + ey);
        e.res  = r[N:0];
        e.flag = sm ? (e.res[N] ^ e.res[N-1]) : e.res[N];
        e.acc  = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) sb.delete();
        else if (in_valid && in_ready) sb.push_back(model(a, b, sub, signed_mode, cyc));
    end

    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (holding) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_out", out, held_out);
                chk("hold_ovf", ovf, held_ovf);
            end
            holding = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got out=0x%0h required no output beat at cycle %0d", out, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result_out", out, mon_e.res);
                    chk("result_ovf", ovf, mon_e.flag);
                    if (lat_strict) chk("latency", cyc - mon_e.acc, 4);
                end
            end else if (out_valid) begin
                holding  = 1'b1;
                held_out = out;
                held_ovf = ovf;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(output bit acc);
        #1;
        acc = in_valid && in_ready && !rst;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] rnd_op();
        case ($urandom % 10)
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("drain_empty", sb.size(), 0);
        tick();
    endtask

    task automatic directed(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                            input logic sm, input logic [N:0] eo, input logic ef);
        bit acc;
        bit got;
        int n;
        lat_strict  = 1'b1;
        out_ready   = 1'b1;
        a           = x;
        b           = y;
        sub         = s;
        signed_mode = sm;
        in_valid    = 1'b1;
        step(acc);
        chk("dir_accept", acc, 1);
        in_valid = 1'b0;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            n = i + 1;
            got = out_valid;
        end
        chk("dir_seen", got, 1);
        chk("dir_latency", n, 4);
        chk("dir_out", out, eo);
        chk("dir_ovf", ovf, ef);
        tick();
    endtask

    initial begin
        bit acc;
        int sent;

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);

        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b1);
        directed(16'h1234, 16'h1111, 1'b0, 1'b0, 17'h02345, 1'b0);
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b1, 17'h08000, 1'b1);
        directed(16'h8000, 16'h0001, 1'b1, 1'b1, 17'h17FFF, 1'b1);
        directed(16'h0003, 16'h0005, 1'b1, 1'b0, 17'h1FFFE, 1'b1);
        directed(16'h0005, 16'h0003, 1'b1, 1'b0, 17'h00002, 1'b0);
        directed(16'h0003, 16'h0005, 1'b1, 1'b1, 17'h1FFFE, 1'b0);
        drain();

        lat_strict = 1'b0;
        sent = 0;
        for (int i = 0; i < 25; i++) begin
            in_valid = (sent < 6);
            a = rnd_op();
            b = rnd_op();
            sub = 1'($urandom);
            signed_mode = 1'($urandom);
            out_ready = !(i >= 5 && i <= 7);
            step(acc);
            if (i >= 5 && i <= 7) chk("stall_no_accept", acc, 0);
            if (acc) sent++;
        end
        chk("stall_sent", sent, 6);
        drain();

        lat_strict = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = rnd_op();
            b = rnd_op();
            sub = 1'($urandom);
            signed_mode = 1'($urandom);
            step(acc);
            chk("flight_accept", acc, 1);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        tick();
        directed(16'h1234, 16'h0FED, 1'b1, 1'b1, 17'h00247, 1'b0);
        drain();

        lat_strict = 1'b0;
        sent = 0;
        for (int i = 0; i < 60000 && sent < 10000; i++) begin
            in_valid = ($urandom % 4) != 0;
            a = rnd_op();
            b = rnd_op();
            sub = 1'($urandom);
            signed_mode = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            step(acc);
            if (acc) sent++;
        end
        chk("random_sent", sent, 10000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit reached required completion");
        $fatal(1, "time limit");
    end
endmodule
